load_unit: RTL and testbench

LOAD_UNIT -- requirements
Module: load_unit

---
 rtl/load_unit_pkg.sv | 39 +++
 rtl/load_ext.sv | 43 ++++
 rtl/load_unit.sv | 114 +++++++++++
 tb/tb_load_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_unit_pkg.sv
// load_unit_pkg
// Definitions shared by the load unit and the store-side data unit:
//   - LDCtrl encodings (lw/lbu/lb/lhu/lh, 5-7 reserved)
//   - FSM state codes of the load unit
//   - helper functions for LDCtrl legality and address alignment
package load_unit_pkg;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LBU = 3'd1;
    localparam logic [2:0] LD_LB  = 3'd2;
    localparam logic [2:0] LD_LHU = 3'd3;
    localparam logic [2:0] LD_LH  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } ld_state_e;

    // Encodings 5-7 are reserved and report an error.
    function automatic logic ld_ctrl_legal(input logic [2:0] ctrl);
        return (ctrl <= LD_LH);
    endfunction

    // Words need Addr[1:0]==0, halves need Addr[0]==0, bytes are always aligned.
    function automatic logic ld_aligned(input logic [2:0] ctrl, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b1;
        case (ctrl)
            LD_LW:         ok = (addr_lo == 2'b00);
            LD_LHU, LD_LH: ok = (addr_lo[0] == 1'b0);
            default:       ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_ext.sv
// load_ext
// Combinational byte/half selection and sign/zero extension of a bus word.
// Ports:
//   rdata   in  32  aligned word read from the bus
//   addr_lo in  2   byte offset within the word (Addr[1:0])
//   ld_ctrl in  3   load type (LD_* encodings)
//   data    out 32  extended load result (0 for reserved types)
module load_ext
    import load_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  ld_ctrl,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = 32'd0;
        case (ld_ctrl)
            LD_LW:   data = rdata;
            LD_LBU:  data = {24'd0, byte_sel};
            LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            LD_LHU:  data = {16'd0, half_sel};
            LD_LH:   data = {{16{half_sel[15]}}, half_sel};
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// load_unit
// MEM-stage load unit: issues one word-aligned bus read per load, extends
// the returned data, and handles pipeline flush and address errors.
// Ports:
//   clk, reset         clock (rising edge) and async active-high reset
//   ld_req, Addr,
//   LDCtrl, flush      load request from the pipeline
//   ld_busy            stall request (combinational)
//   ld_done, Dout      one-cycle completion pulse and extended result
//   ld_err             one-cycle address error / reserved-type pulse
//   bus_req, bus_addr,
//   bus_ack, bus_rdata read bus
//   dbg_state          current FSM state, for observation only
//
// Bus handshake: bus_req rises when a load is accepted and stays high with
// bus_addr stable until the cycle in which bus_ack=1 (that cycle may be the
// first bus_req cycle); bus_rdata is taken only in that cycle. bus_ack while
// bus_req=0 is ignored.
module load_unit
    import load_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_req,
    input  logic [31:0] Addr,
    input  logic [2:0]  LDCtrl,
    input  logic        flush,
    output logic        ld_busy,
    output logic        ld_done,
    output logic [31:0] Dout,
    output logic        ld_err,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output ld_state_e   dbg_state
);

    ld_state_e   state_q, state_d;
    logic [1:0]  addr_lo_q;
    logic [2:0]  ctrl_q;
    logic [31:0] bus_addr_q;
    logic [31:0] dout_q;
    logic [31:0] ext_data;
    logic        req_ok;
    logic        accept;
    logic        reject;

    assign req_ok = ld_ctrl_legal(LDCtrl) && ld_aligned(LDCtrl, Addr[1:0]);
    assign accept = ld_req && !flush && req_ok;
    assign reject = ld_req && !flush && !req_ok;

    load_ext u_load_ext (
        .rdata   (bus_rdata),
        .addr_lo (addr_lo_q),
        .ld_ctrl (ctrl_q),
        .data    (ext_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept)      state_d = ST_WAIT;
                else if (reject) state_d = ST_ERR;
            end
            ST_WAIT: begin
                // A flush abandons the load; if the bus is still busy we
                // must keep requesting until it acks (DRAIN).
                if (flush)        state_d = bus_ack ? ST_IDLE : ST_DRAIN;
                else if (bus_ack) state_d = ST_DONE;
            end
            ST_DRAIN: begin
                if (bus_ack) state_d = ST_IDLE;
            end
            // DONE ignores ld_req: the same instruction is still in MEM.
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_req = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
        ld_busy = bus_req || ((state_q == ST_IDLE) && accept);
        ld_done = (state_q == ST_DONE) && !flush;
        ld_err  = (state_q == ST_ERR) && !flush;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_lo_q  <= 2'd0;
            ctrl_q     <= 3'd0;
            bus_addr_q <= 32'd0;
            dout_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && accept) begin
                addr_lo_q  <= Addr[1:0];
                ctrl_q     <= LDCtrl;
                bus_addr_q <= {Addr[31:2], 2'b00};
            end
            if ((state_q == ST_WAIT) && bus_ack && !flush) begin
                dout_q <= ext_data;
            end
        end
    end

    assign bus_addr  = bus_addr_q;
    assign Dout      = dout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;
    import load_unit_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        ld_req;
    logic [31:0] Addr;
    logic [2:0]  LDCtrl;
    logic        flush;
    logic        ld_busy;
    logic        ld_done;
    logic [31:0] Dout;
    logic        ld_err;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    ld_state_e   dbg_state;

    always #5 clk = ~clk;

    load_unit dut (
        .clk       (clk),
        .reset     (reset),
        .ld_req    (ld_req),
        .Addr      (Addr),
        .LDCtrl    (LDCtrl),
        .flush     (flush),
        .ld_busy   (ld_busy),
        .ld_done   (ld_done),
        .Dout      (Dout),
        .ld_err    (ld_err),
        .bus_req   (bus_req),
        .bus_addr  (bus_addr),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [31:0] last_dout = 32'd0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference model: what a load returns, from the architectural rules.
    function automatic void model(input logic [2:0] c, input logic [31:0] a,
                                  input logic [31:0] rd, output logic err,
                                  output logic [31:0] d);
        int unsigned w, k, b, h;
        w = rd;
        k = a % 4;
        b = (w >> (8 * k)) % 256;
        h = (w >> (16 * (k / 2))) % 65536;
        err = 1'b0;
        d = 32'd0;
        case (c)
            3'd0: begin err = (k != 0); d = w; end
            3'd1: d = b;
            3'd2: d = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd3: begin err = (k % 2 != 0); d = h; end
            3'd4: begin err = (k % 2 != 0); d = (h >= 32768) ? h + 32'hFFFF_0000 : h; end
            default: err = 1'b1;
        endcase
    endfunction

    // ---------------- driver ----------------
    // Issues one load starting at the next negedge (cycle N) and checks the
    // whole transaction cycle by cycle. delay = idle-ack cycles in WAIT.
    task automatic run_load(input string tag, input logic [2:0] c, input logic [31:0] a,
                            input logic [31:0] rd, input int delay,
                            input logic exp_err, input logic [31:0] exp_dout);
        @(negedge clk);
        ld_req = 1'b1; Addr = a; LDCtrl = c; flush = 1'b0;
        #1;
        check({tag, " busy@N"}, ld_busy, !exp_err);
        @(negedge clk);
        ld_req = 1'b0; Addr = $urandom; LDCtrl = 3'($urandom_range(0, 7));
        #1;
        if (exp_err) begin
            check({tag, " err@N+1"}, ld_err, 1'b1);
            check({tag, " no_bus_req"}, bus_req, 1'b0);
            check({tag, " busy@N+1"}, ld_busy, 1'b0);
            @(negedge clk);
            #1;
            check({tag, " err_pulse_end"}, ld_err, 1'b0);
            check({tag, " dout_held"}, Dout, last_dout);
        end else begin
            check({tag, " bus_req"}, bus_req, 1'b1);
            check({tag, " bus_addr"}, bus_addr, {a[31:2], 2'b00});
            for (int i = 0; i < delay; i++) begin
                @(negedge clk);
                #1;
                check({tag, " req_hold"}, bus_req, 1'b1);
                check({tag, " no_early_done"}, ld_done, 1'b0);
            end
            bus_ack = 1'b1; bus_rdata = rd;
            #1;
            check({tag, " busy_ack"}, ld_busy, 1'b1);
            @(negedge clk);
            bus_ack = 1'b0; bus_rdata = $urandom;
            #1;
            exp_q.push_back(exp_dout);
            check({tag, " done"}, ld_done, 1'b1);
            check({tag, " dout"}, Dout, exp_q.pop_front());
            check({tag, " req_drop"}, bus_req, 1'b0);
            last_dout = exp_dout;
            @(negedge clk);
            #1;
            check({tag, " done_pulse_end"}, ld_done, 1'b0);
            check({tag, " dout_hold"}, Dout, last_dout);
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] rdata;
        int          delay;
        logic        exp_err;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic        m_err;
        logic [31:0] m_dout;
        logic [2:0]  rc;
        logic [31:0] ra, rr;

        vecs[0]  = '{3'd2, 32'h0000_1003, 32'h80AB_CD12, 0, 1'b0, 32'hFFFF_FF80};
        vecs[1]  = '{3'd1, 32'h0000_1003, 32'h80AB_CD12, 0, 1'b0, 32'h0000_0080};
        vecs[2]  = '{3'd4, 32'h0000_1002, 32'h8001_7FFF, 0, 1'b0, 32'hFFFF_8001};
        vecs[3]  = '{3'd3, 32'h0000_1002, 32'h8001_7FFF, 1, 1'b0, 32'h0000_8001};
        vecs[4]  = '{3'd0, 32'h0000_1002, 32'h1111_1111, 0, 1'b1, 32'h0};
        vecs[5]  = '{3'd6, 32'h0000_1000, 32'h1111_1111, 0, 1'b1, 32'h0};
        vecs[6]  = '{3'd0, 32'h0000_2000, 32'hDEAD_BEEF, 2, 1'b0, 32'hDEAD_BEEF};
        vecs[7]  = '{3'd2, 32'h0000_1000, 32'h80AB_CD12, 0, 1'b0, 32'h0000_0012};
        vecs[8]  = '{3'd2, 32'h0000_1001, 32'h80AB_CD12, 3, 1'b0, 32'hFFFF_FFCD};
        vecs[9]  = '{3'd4, 32'h0000_1001, 32'h8001_7FFF, 0, 1'b1, 32'h0};
        vecs[10] = '{3'd3, 32'h0000_1000, 32'h8001_7FFF, 0, 1'b0, 32'h0000_7FFF};
        vecs[11] = '{3'd1, 32'hFFFF_FFFE, 32'h80AB_CD12, 1, 1'b0, 32'h0000_00AB};

        reset = 1'b1; ld_req = 1'b0; Addr = 32'd0; LDCtrl = 3'd0; flush = 1'b0;
        bus_ack = 1'b0; bus_rdata = 32'd0;
        #1;
        check("rst bus_req", bus_req, 1'b0);
        check("rst ld_done", ld_done, 1'b0);
        check("rst ld_err", ld_err, 1'b0);
        check("rst Dout", Dout, 32'd0);
        check("rst bus_addr", bus_addr, 32'd0);
        check("rst ld_busy", ld_busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven directed loads.
        for (int i = 0; i < 12; i++) begin
            run_load($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].addr, vecs[i].rdata,
                     vecs[i].delay, vecs[i].exp_err, vecs[i].exp_dout);
        end

        // Flush while waiting, ack arrives 3 cycles later: drain, no done.
        @(negedge clk);
        ld_req = 1'b1; Addr = 32'h0000_3000; LDCtrl = 3'd0; flush = 1'b0;
        @(negedge clk);
        ld_req = 1'b0; flush = 1'b1;
        #1;
        check("flush bus_req", bus_req, 1'b1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("drain bus_req1", bus_req, 1'b1);
        check("drain busy", ld_busy, 1'b1);
        @(negedge clk);
        #1;
        check("drain bus_req2", bus_req, 1'b1);
        bus_ack = 1'b1; bus_rdata = 32'hAAAA_5555;
        #1;
        check("drain bus_req_ack", bus_req, 1'b1);
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        check("drain no_done", ld_done, 1'b0);
        check("drain idle", bus_req, 1'b0);
        check("drain dout_kept", Dout, last_dout);
        run_load("after_drain", 3'd0, 32'h0000_4000, 32'h1234_5678, 0, 1'b0, 32'h1234_5678);

        // Flush coinciding with ack: data discarded, straight back to idle.
        @(negedge clk);
        ld_req = 1'b1; Addr = 32'h0000_5004; LDCtrl = 3'd0;
        @(negedge clk);
        ld_req = 1'b0; flush = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        flush = 1'b0; bus_ack = 1'b0;
        #1;
        check("flush_ack no_done", ld_done, 1'b0);
        check("flush_ack idle", bus_req, 1'b0);
        check("flush_ack dout", Dout, last_dout);

        // Flush in IDLE: request ignored.
        @(negedge clk);
        ld_req = 1'b1; Addr = 32'h0000_6000; LDCtrl = 3'd0; flush = 1'b1;
        #1;
        check("idle_flush busy", ld_busy, 1'b0);
        @(negedge clk);
        ld_req = 1'b0; flush = 1'b0;
        #1;
        check("idle_flush no_req", bus_req, 1'b0);
        check("idle_flush no_err", ld_err, 1'b0);

        // Flush during DONE/ERR suppresses the pulses.
        @(negedge clk);
        ld_req = 1'b1; Addr = 32'h0000_7000; LDCtrl = 3'd0;
        @(negedge clk);
        ld_req = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        bus_ack = 1'b0; flush = 1'b1;
        #1;
        check("done_flush no_done", ld_done, 1'b0);
        last_dout = 32'h0BAD_F00D;
        @(negedge clk);
        flush = 1'b0;
        ld_req = 1'b1; Addr = 32'h0000_7001; LDCtrl = 3'd3;
        @(negedge clk);
        ld_req = 1'b0; flush = 1'b1;
        #1;
        check("err_flush no_err", ld_err, 1'b0);
        @(negedge clk);
        flush = 1'b0;

        // Randomized loads against the reference model.
        for (int i = 0; i < 40; i++) begin
            rc = 3'($urandom_range(0, 7));
            ra = $urandom;
            rr = $urandom;
            model(rc, ra, rr, m_err, m_dout);
            run_load($sformatf("rnd%0d", i), rc, ra, rr, $urandom_range(0, 3), m_err, m_dout);
        end

        // Asynchronous reset in the middle of WAIT.
        @(negedge clk);
        ld_req = 1'b1; Addr = 32'h0000_8008; LDCtrl = 3'd0;
        @(negedge clk);
        ld_req = 1'b0;
        #1;
        check("pre_rst bus_req", bus_req, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst bus_req", bus_req, 1'b0);
        check("async_rst ld_done", ld_done, 1'b0);
        check("async_rst Dout", Dout, 32'd0);
        check("async_rst bus_addr", bus_addr, 32'd0);
        last_dout = 32'd0;
        @(negedge clk);
        reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        check("stray_ack no_done", ld_done, 1'b0);
        check("stray_ack no_req", bus_req, 1'b0);
        check("stray_ack Dout", Dout, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
